// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the fetch stage: opcodes, status codes,
// register "none" id, bubble contents and fetch FSM states.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [3:0] BUBBLE_ICODE = INOP;
    localparam logic [3:0] BUBBLE_IFUN  = 4'h0;
    localparam logic [2:0] BUBBLE_STAT  = STAT_AOK;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } fetch_state_t;

    // Encoded length: opcode byte, optional register byte, optional 8-byte constant.
    function automatic logic [3:0] instr_len(input logic need_regids, input logic need_valc);
        return 4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0);
    endfunction

endpackage

// File: rtl/fetch_align.sv
// Combinational split of the 10 fetched bytes into Y86-64 instruction fields.
module fetch_align
    import y86_pkg::*;
(
    input  logic [79:0] imem_bytes,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] valc,
    output logic        need_regids,
    output logic        need_valc,
    output logic        icode_valid
);

    always_comb begin
        icode       = imem_bytes[7:4];
        ifun        = imem_bytes[3:0];
        icode_valid = (icode <= IPOPQ);
        need_regids = icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
        need_valc   = icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
        ra          = need_regids ? imem_bytes[15:12] : REG_NONE;
        rb          = need_regids ? imem_bytes[11:8]  : REG_NONE;
        // The constant shifts up one byte when a register byte precedes it.
        if (!need_valc)
            valc = '0;
        else if (need_regids)
            valc = imem_bytes[79:16];
        else
            valc = imem_bytes[71:8];
    end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, prediction, F/D pipeline registers and halt FSM.
// Optional FETCH_PERF_EN adds saturating fetched/stall performance counters.
module fetch_stage
    import y86_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [79:0]     imem_bytes,
    input  logic            imem_error,
    input  logic            F_stall,
    input  logic            D_stall,
    input  logic            D_bubble,
    input  logic [3:0]      M_icode,
    input  logic            M_cnd,
    input  logic [XLEN-1:0] M_valA,
    input  logic [3:0]      W_icode,
    input  logic [XLEN-1:0] W_valM,
    output logic [XLEN-1:0] f_pc,
    output logic [3:0]      D_icode,
    output logic [3:0]      D_ifun,
    output logic [3:0]      D_rA,
    output logic [3:0]      D_rB,
    output logic [XLEN-1:0] D_valC,
    output logic [XLEN-1:0] D_valP,
    output logic [2:0]      D_stat,
    output logic            f_halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall
`endif
);

    fetch_state_t    state;
    logic [XLEN-1:0] pred_pc;

    logic [3:0]      f_icode, f_ifun, f_ra, f_rb;
    logic [63:0]     f_valc;
    logic            need_regids, need_valc, icode_valid;
    logic [XLEN-1:0] f_valp, f_pred;
    logic [2:0]      f_stat;
    logic            mispredict, ret_redirect, redirect;
    logic            halted, d_load_fetch;

    fetch_align u_align (
        .imem_bytes  (imem_bytes),
        .icode       (f_icode),
        .ifun        (f_ifun),
        .ra          (f_ra),
        .rb          (f_rb),
        .valc        (f_valc),
        .need_regids (need_regids),
        .need_valc   (need_valc),
        .icode_valid (icode_valid)
    );

    assign mispredict   = (M_icode == IJXX) && !M_cnd;
    assign ret_redirect = (W_icode == IRET);
    assign redirect     = mispredict || ret_redirect;
    assign halted       = (state == ST_HALTED);
    assign f_halted     = halted;

    always_comb begin
        if (mispredict)
            f_pc = M_valA;
        else if (ret_redirect)
            f_pc = W_valM;
        else
            f_pc = pred_pc;
    end

    always_comb begin
        f_valp = f_pc + XLEN'(instr_len(need_regids, need_valc));
        f_pred = (f_icode == IJXX || f_icode == ICALL) ? XLEN'(f_valc) : f_valp;
        if (imem_error)
            f_stat = STAT_ADR;
        else if (!icode_valid)
            f_stat = STAT_INS;
        else if (f_icode == IHALT)
            f_stat = STAT_HLT;
        else
            f_stat = STAT_AOK;
    end

    // While halted, only a redirect lets a real instruction into D.
    assign d_load_fetch = !D_stall && !D_bubble && (!halted || redirect);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_pc <= RESET_PC;
            state   <= ST_RUN;
        end else begin
            if (!F_stall && (!halted || redirect))
                pred_pc <= f_pred;
            case (state)
                ST_RUN:
                    if (f_stat != STAT_AOK && !F_stall && !redirect)
                        state <= ST_HALTED;
                ST_HALTED:
                    if (redirect)
                        state <= ST_RUN;
                default:
                    state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D_icode <= BUBBLE_ICODE;
            D_ifun  <= BUBBLE_IFUN;
            D_rA    <= REG_NONE;
            D_rB    <= REG_NONE;
            D_valC  <= '0;
            D_valP  <= '0;
            D_stat  <= BUBBLE_STAT;
        end else if (d_load_fetch) begin
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_ra;
            D_rB    <= f_rb;
            D_valC  <= XLEN'(f_valc);
            D_valP  <= f_valp;
            D_stat  <= f_stat;
        end else if (!D_stall) begin
            D_icode <= BUBBLE_ICODE;
            D_ifun  <= BUBBLE_IFUN;
            D_rA    <= REG_NONE;
            D_rB    <= REG_NONE;
            D_valC  <= '0;
            D_valP  <= '0;
            D_stat  <= BUBBLE_STAT;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (d_load_fetch && perf_fetched != '1)
                perf_fetched <= perf_fetched + 32'd1;
            if (F_stall && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed steps plus random traffic
// compared against a byte-level reference model of the fetch rules.
module tb_fetch_stage;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [2:0]  stat;
    } d_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [79:0] imem_bytes;
    logic        imem_error, F_stall, D_stall, D_bubble;
    logic [3:0]  M_icode, W_icode;
    logic        M_cnd;
    logic [63:0] M_valA, W_valM;
    logic [63:0] f_pc, D_valC, D_valP;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [2:0]  D_stat;
    logic        f_halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_bytes(imem_bytes), .imem_error(imem_error),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM), .f_pc(f_pc),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat), .f_halted(f_halted)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] m_pred, m_fpc, m_fpred;
    bit          m_halted, m_redir;
    d_t          m_d, m_f, snap;

    function automatic d_t bubble();
        d_t b;
        b = '{icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h0, valp: 64'h0, stat: 3'd1};
        return b;
    endfunction

    // Reference decode straight from the instruction-format rules.
    function automatic void model_fetch(input logic [79:0] bytes, input logic err,
                                        input logic [63:0] pc, output d_t f,
                                        output logic [63:0] pred);
        logic [7:0] b [10];
        int unsigned len;
        int unsigned base;
        bit regs, cst;
        for (int i = 0; i < 10; i++) b[i] = bytes[8*i +: 8];
        f.icode = b[0][7:4];
        f.ifun  = b[0][3:0];
        regs = (f.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
        cst  = (f.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
        f.ra = regs ? b[1][7:4] : 4'hF;
        f.rb = regs ? b[1][3:0] : 4'hF;
        f.valc = 64'h0;
        base = regs ? 2 : 1;
        if (cst)
            for (int k = 0; k < 8; k++) f.valc = f.valc | (64'(b[base + k]) << (8 * k));
        len = 1 + (regs ? 1 : 0) + (cst ? 8 : 0);
        f.valp = pc + 64'(len);
        if (err)                f.stat = 3'd3;
        else if (f.icode > 11)  f.stat = 3'd4;
        else if (f.icode == 0)  f.stat = 3'd2;
        else                    f.stat = 3'd1;
        pred = (f.icode == 4'h7 || f.icode == 4'h8) ? f.valc : f.valp;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pred   = 64'h0;
        m_halted = 1'b0;
        m_d      = bubble();
    endtask

    // Apply inputs mid-cycle and check the combinational fetch address.
    task automatic drive(input logic [79:0] b, input logic err, input logic fs, input logic ds,
                         input logic db, input logic [3:0] mi, input logic mc,
                         input logic [63:0] mva, input logic [3:0] wi, input logic [63:0] wvm);
        @(negedge clk);
        imem_bytes = b; imem_error = err; F_stall = fs; D_stall = ds; D_bubble = db;
        M_icode = mi; M_cnd = mc; M_valA = mva; W_icode = wi; W_valM = wvm;
        #1;
        m_redir = (mi == 4'h7 && !mc) || (wi == 4'h9);
        m_fpc = (mi == 4'h7 && !mc) ? mva : (wi == 4'h9) ? wvm : m_pred;
        model_fetch(b, err, m_fpc, m_f, m_fpred);
        chk("f_pc", f_pc, m_fpc);
    endtask

    // Clock edge: advance the model and compare every D-side output.
    task automatic tick();
        bit was_halted;
        @(posedge clk);
        was_halted = m_halted;
        if (!F_stall && (!was_halted || m_redir)) m_pred = m_fpred;
        if (!was_halted) begin
            if (m_f.stat != 3'd1 && !F_stall && !m_redir) m_halted = 1'b1;
        end else if (m_redir) begin
            m_halted = 1'b0;
        end
        if (!D_stall)
            m_d = (D_bubble || (was_halted && !m_redir)) ? bubble() : m_f;
        #1;
        chk("D_icode", 64'(D_icode), 64'(m_d.icode));
        chk("D_ifun", 64'(D_ifun), 64'(m_d.ifun));
        chk("D_rA", 64'(D_rA), 64'(m_d.ra));
        chk("D_rB", 64'(D_rB), 64'(m_d.rb));
        chk("D_valC", D_valC, m_d.valc);
        chk("D_valP", D_valP, m_d.valp);
        chk("D_stat", 64'(D_stat), 64'(m_d.stat));
        chk("f_halted", 64'(f_halted), 64'(m_halted));
    endtask

    task automatic plain(input logic [79:0] b);
        drive(b, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0);
    endtask

    task automatic check_snapshot(input string tag);
        chk({tag, "_icode"}, 64'(D_icode), 64'(snap.icode));
        chk({tag, "_rB"}, 64'(D_rB), 64'(snap.rb));
        chk({tag, "_valC"}, D_valC, snap.valc);
        chk({tag, "_valP"}, D_valP, snap.valp);
        chk({tag, "_stat"}, 64'(D_stat), 64'(snap.stat));
        chk({tag, "_fpc"}, f_pc, 64'h20);
    endtask

    initial begin
        logic [95:0] r;
        logic [79:0] rb;
        logic [3:0]  ic;

        rst_n = 1'b0; imem_bytes = 80'h10; imem_error = 1'b0;
        F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        M_icode = 4'h0; M_cnd = 1'b0; M_valA = 64'h0; W_icode = 4'h0; W_valM = 64'h0;
        model_reset();
        #16;
        chk("rst_D_icode", 64'(D_icode), 64'h1);
        chk("rst_D_rA", 64'(D_rA), 64'hF);
        chk("rst_D_stat", 64'(D_stat), 64'h1);
        chk("rst_f_halted", 64'(f_halted), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_f_pc", f_pc, 64'h0);

        // irmovq $10,%rdx at 0
        plain(80'h0A_F230);
        tick();
        chk("irmov_icode", 64'(D_icode), 64'h3);
        chk("irmov_rB", 64'(D_rB), 64'h2);
        chk("irmov_valC", D_valC, 64'd10);
        chk("irmov_valP", D_valP, 64'd10);
        // jmp 0x10 at 0xA, then jmp 0x40 at 0x10
        plain(80'h10_70);
        chk("fpc_after_irmov", f_pc, 64'd10);
        tick();
        plain(80'h40_70);
        chk("fpc_jmp_target", f_pc, 64'h10);
        tick();
        // Mispredict and ret in the same cycle: mispredict wins
        drive(80'h10, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 1'b0, 64'h19, 4'h9, 64'h80);
        chk("fpc_mispredict", f_pc, 64'h19);
        tick();
        plain(80'h20_70);
        chk("fpc_after_nop", f_pc, 64'h1A);
        tick();

        // Stall both registers while the memory bytes churn
        snap = m_d;
        for (int i = 0; i < 3; i++) begin
            r = {$urandom, $urandom, $urandom}; rb = r[79:0];
            drive(rb, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0);
            tick();
        end
        check_snapshot("stall");
        drive(80'h10, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0);
        tick();
        check_snapshot("stall_bubble");

        // halt at 0x20
        plain(80'h00);
        chk("fpc_halt", f_pc, 64'h20);
        tick();
        chk("halt_stat", 64'(D_stat), 64'h2);
        chk("halt_flag", 64'(f_halted), 64'h1);
        for (int i = 0; i < 2; i++) begin
            plain(80'h10_70);
            chk("fpc_frozen", f_pc, 64'h21);
            tick();
            chk("halted_bubble", 64'(D_icode), 64'h1);
        end
        drive(80'h23_60, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h9, 64'h80);
        chk("fpc_ret_wake", f_pc, 64'h80);
        tick();
        chk("wake_run", 64'(f_halted), 64'h0);
        chk("wake_icode", 64'(D_icode), 64'h6);
        plain(80'hF0);
        chk("fpc_after_opq", f_pc, 64'h82);
        tick();
        chk("ins_stat", 64'(D_stat), 64'h4);
        drive(80'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 4'h9, 64'h100);
        tick();
        chk("adr_stat", 64'(D_stat), 64'h3);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            r = {$urandom, $urandom, $urandom}; rb = r[79:0];
            if ($urandom_range(0, 19) == 0)      ic = 4'h0;
            else if ($urandom_range(0, 19) == 0) ic = 4'(12 + $urandom_range(0, 3));
            else                                 ic = 4'($urandom_range(1, 11));
            rb[7:4] = ic;
            drive(rb, ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 5) == 0) ? 4'h7 : 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), {$urandom, $urandom},
                  ($urandom_range(0, 5) == 0) ? 4'h9 : 4'($urandom_range(0, 15)),
                  {$urandom, $urandom});
            tick();
        end

        // Asynchronous reset in the middle of a stall
        @(negedge clk);
        F_stall = 1'b1; D_stall = 1'b1; M_icode = 4'h0; W_icode = 4'h0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_D_icode", 64'(D_icode), 64'h1);
        chk("arst_D_valP", D_valP, 64'h0);
        chk("arst_f_pc", f_pc, 64'h0);
        chk("arst_f_halted", 64'(f_halted), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            r = {$urandom, $urandom, $urandom}; rb = r[79:0];
            rb[7:4] = 4'($urandom_range(1, 11));
            plain(rb);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
